ext_unit_pipe: RTL and testbench
================================

EXT_UNIT_PIPE -- requirements
Module: ext_unit_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 16: immediate input width.
REQ-002 The block SHALL have parameter OUT_W, default 32: extended output width; legal only when OUT_W >= IN_W+2.
REQ-003 The block SHALL have parameter TAG_W, default 5: width of the sideband tag carried with each immediate.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous discard of all buffered results.
REQ-007 in_valid  input  1  request presented.
REQ-008 in_ready  output  1  block can accept a request this cycle.
REQ-009 in_imm  input  IN_W  raw immediate.
REQ-010 in_op  input  2  extension mode, encoded as in REQ-017.
REQ-011 in_tag  input  TAG_W  sideband tag, returned unmodified.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 out_imm  output  OUT_W  extended result.
REQ-015 out_tag  output  TAG_W  tag of out_imm.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 Modes SHALL be: 00 sign-extend ({OUT_W-IN_W copies of in_imm[IN_W-1]}, in_imm); 01 zero-extend; 10 upper (in_imm in the top IN_W bits, zeros below); 11 branch offset (sign-extend, then shift left 2, dropping the top 2 bits).
REQ-018 The result SHALL be computed combinationally at accept and written with its tag into a 2-entry FIFO at the same edge.
REQ-019 Latency SHALL be 1 cycle: a request accepted at edge N SHALL appear on out_* after edge N, provided the FIFO was empty.
REQ-020 The FIFO SHALL keep a 2-bit count (0..2) and 1-bit read/write pointers that wrap 1->0.
REQ-021 in_ready SHALL be (count != 2), with no combinational path from out_ready.
REQ-022 out_valid SHALL be (count != 0); out_imm and out_tag SHALL show the entry at the read pointer.
REQ-023 A simultaneous accept and pop with count 1 SHALL leave count at 1 and advance both pointers.
REQ-024 At count 2, a pop SHALL lower count to 1; no accept is possible in that cycle, even with out_ready high.
REQ-025 out_imm and out_tag SHALL hold stable while out_valid && !out_ready.
REQ-026 At the next edge, flush SHALL set count and both pointers to 0 and discard any accept or pop in that cycle; flush SHALL have lower priority than rst_n.
REQ-027 in_op SHALL be sampled only at accept; a change while not accepting SHALL have no effect.

Reset
REQ-028 At an edge with rst_n low, count, pointers, out_valid, out_imm and out_tag SHALL be 0, and in_ready SHALL be 1 from the following cycle.
REQ-029 A reset arriving while entries are buffered SHALL discard them; no result SHALL emerge after reset.
REQ-030 FIFO storage contents need not be reset, but out_imm and out_tag SHALL read 0 while count is 0 after reset.

Verification
REQ-031 Modes at 16->32, out_ready=1:
- in_imm 0x8001 with op 00/01/10/11 -> 0xFFFF8001 / 0x00008001 / 0x80010000 / 0xFFFE0004, each one cycle after accept.
- in_imm 0x7FFF with op 11 -> 0x0001FFFC.
REQ-032 Backpressure: out_ready=0, three back-to-back requests -> in_ready drops after two accepts; the third is held; when out_ready rises, results pop in order with their tags.
REQ-033 Simultaneous accept and pop: streaming with count 1 and both handshakes every cycle -> count stays 1 and there is one result per cycle, in order.
REQ-034 Flush: two buffered entries, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, and the concurrent request is dropped.
REQ-035 Reset mid-operation: rst_n=0 for one edge with count=2 -> out_valid=0, out_imm=0, in_ready=1 afterwards, and no stale result is emitted.
REQ-036 Parameter sweep: IN_W=12, OUT_W=32, in_imm 0x800 with op 00/10/11 -> 0xFFFFF800 / 0x80000000 / 0xFFFFE000.

Source files
------------

// File: rtl/ext_unit_pipe_if.sv
// Request/response bundle for the immediate-extension pipe.
// The master drives requests and out_ready; the slave (the block) drives the rest.
`timescale 1ns/1ps
interface ext_unit_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_imm, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag
    );
endinterface

// File: rtl/ext_unit_pipe.sv
// Immediate extension unit: extends at accept time and buffers result+tag in a
// 2-entry FIFO, giving one cycle of latency and full throughput.
`timescale 1ns/1ps
module ext_unit_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,   // must be >= IN_W+2
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    ext_unit_pipe_if.slave bus
);
    localparam int PAD_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    typedef struct packed {
        logic [OUT_W-1:0] imm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      op);
        logic [OUT_W-1:0] sext;
        sext = {{PAD_W{imm[IN_W-1]}}, imm};
        case (mode_e'(op))
            MODE_SEXT:   extend = sext;
            MODE_ZEXT:   extend = {{PAD_W{1'b0}}, imm};
            MODE_UPPER:  extend = {imm, {PAD_W{1'b0}}};
            MODE_BRANCH: extend = sext << 2;
            default:     extend = sext;
        endcase
    endfunction

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    entry_t     mem_q [0:1];
    entry_t     mem_d [0:1];
    entry_t     new_entry;
    logic       accept, pop;

    // in_ready depends only on the count, so out_ready never reaches it.
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Storage is not reset; gate the head so an empty FIFO always reads zero.
    assign bus.out_imm = bus.out_valid ? mem_q[rd_ptr_q].imm : '0;
    assign bus.out_tag = bus.out_valid ? mem_q[rd_ptr_q].tag : '0;

    always_comb begin
        new_entry.imm = extend(bus.in_imm, bus.in_op);
        new_entry.tag = bus.in_tag;
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (accept) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            case ({accept, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_ext_unit_pipe.sv
// Bench for ext_unit_pipe: mode table, handshake corner sequences, random traffic
// against a queue-based reference, and a 12-bit-input instance.
`timescale 1ns/1ps
module tb_ext_unit_pipe;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ext_unit_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();
    ext_unit_pipe_if #(.IN_W(12), .OUT_W(32), .TAG_W(5)) bus12 ();

    ext_unit_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
    );
    ext_unit_pipe #(.IN_W(12), .OUT_W(32), .TAG_W(5)) dut12 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus12)
    );

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [11:0] imm;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec12_t;

    exp_t mq[$];
    bit   fresh;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension from value arithmetic rather than bit concatenation.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] op);
        longint s;
        s = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
        case (op)
            2'd0:    return 32'(s);
            2'd1:    return 32'(imm);
            2'd2:    return 32'(longint'(imm) * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    // One clock: check the DUT against the model, then advance the model.
    task automatic cycle();
        bit   acc, pp;
        exp_t e;
        acc = bus.in_valid && (mq.size() != 2);
        pp  = bus.out_ready && (mq.size() != 0);
        chk("in_ready", 64'(bus.in_ready), 64'(mq.size() != 2));
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_imm", 64'(bus.out_imm), 64'(mq[0].imm));
            chk("out_tag", 64'(bus.out_tag), 64'(mq[0].tag));
        end else if (fresh) begin
            chk("out_imm_empty", 64'(bus.out_imm), 64'd0);
            chk("out_tag_empty", 64'(bus.out_tag), 64'd0);
        end
        e.imm = ref_ext(bus.in_imm, bus.in_op);
        e.tag = bus.in_tag;
        @(posedge clk);
        #1;
        if (!rst_n || flush) begin
            mq.delete();
            if (!rst_n) fresh = 1'b1;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                fresh = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] op,
                         input logic [4:0] tag);
        bus.in_valid = v;
        bus.in_imm   = imm;
        bus.in_op    = op;
        bus.in_tag   = tag;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   tbl[5];
        vec12_t tbl12[3];
        tbl[0] = '{16'h8001, 2'b00, 32'hFFFF8001};
        tbl[1] = '{16'h8001, 2'b01, 32'h00008001};
        tbl[2] = '{16'h8001, 2'b10, 32'h80010000};
        tbl[3] = '{16'h8001, 2'b11, 32'hFFFE0004};
        tbl[4] = '{16'h7FFF, 2'b11, 32'h0001FFFC};
        tbl12[0] = '{12'h800, 2'b00, 32'hFFFFF800};
        tbl12[1] = '{12'h800, 2'b10, 32'h80000000};
        tbl12[2] = '{12'h800, 2'b11, 32'hFFFFE000};

        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        bus.out_ready   = 1'b1;
        bus12.in_valid  = 1'b0;
        bus12.in_imm    = '0;
        bus12.in_op     = '0;
        bus12.in_tag    = '0;
        bus12.out_ready = 1'b1;
        fresh = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_imm", 64'(bus.out_imm), 64'd0);
        rst_n = 1'b1;
        cycle();

        // Mode table, one request at a time with out_ready high.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, tbl[i].imm, tbl[i].op, 5'(i + 1));
            cycle();
            drive(1'b0, '0, '0, '0);
            chk("tbl_valid", 64'(bus.out_valid), 64'd1);
            chk("tbl_imm", 64'(bus.out_imm), 64'(tbl[i].exp));
            cycle();
        end

        // 12-bit instance.
        for (int i = 0; i < 3; i++) begin
            bus12.in_valid = 1'b1;
            bus12.in_imm   = tbl12[i].imm;
            bus12.in_op    = tbl12[i].op;
            bus12.in_tag   = 5'(i + 9);
            @(posedge clk);
            #1;
            bus12.in_valid = 1'b0;
            chk("w12_valid", 64'(bus12.out_valid), 64'd1);
            chk("w12_imm", 64'(bus12.out_imm), 64'(tbl12[i].exp));
            chk("w12_tag", 64'(bus12.out_tag), 64'(i + 9));
            @(posedge clk);
            #1;
        end

        // Backpressure: third request held; its op toggles while stalled.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1234, 2'b00, 5'd20); cycle();
        drive(1'b1, 16'hF00D, 2'b01, 5'd21); cycle();
        drive(1'b1, 16'hABCD, 2'b10, 5'd22);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        cycle();
        bus.in_op = 2'b11;
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        drive(1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // Streaming at count 1: accept and pop every cycle.
        drive(1'b1, 16'h0100, 2'b00, 5'd1);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16'h0200 + i), 2'(i), 5'(i + 2));
            cycle();
            chk("stream_valid", 64'(bus.out_valid), 64'd1);
            chk("stream_ready", 64'(bus.in_ready), 64'd1);
        end
        drive(1'b0, '0, '0, '0);
        cycle(); cycle();

        // Flush with two buffered entries and a concurrent request.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1111, 2'b00, 5'd3); cycle();
        drive(1'b1, 16'h2222, 2'b00, 5'd4); cycle();
        drive(1'b1, 16'h3333, 2'b00, 5'd5);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        cycle();
        chk("flush_dropped", 64'(bus.out_valid), 64'd0);

        // Reset with count 2; nothing stale may emerge afterwards.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h4444, 2'b01, 5'd6); cycle();
        drive(1'b1, 16'h5555, 2'b01, 5'd7); cycle();
        drive(1'b0, '0, '0, '0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), 5'($urandom));
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
